// File: rtl/term_pkg.sv
// Shared constants and state encoding for the 80x25 text-mode terminal writer.
package term_pkg;

  localparam int COLS  = 80;
  localparam int ROWS  = 25;
  localparam int CELLS = COLS * ROWS;

  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] FF    = 8'h0C;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] SPACE = 8'h20;

  typedef enum logic [1:0] {
    IDLE,
    PUT,
    CLR_LINE,
    CLR_SCR
  } state_t;

endpackage

// File: rtl/term_writer.sv
// Consumes an ASCII byte stream and renders it into an 80x25 screen RAM,
// handling cursor motion, line feeds, backspace and full-screen clears.
module term_writer
  import term_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  char_data_i,
  input  logic        char_valid_i,
  output logic        char_ready_o,
  output logic [10:0] ram_addr_o,
  output logic [7:0]  ram_data_o,
  output logic        ram_wren_o,
  output logic [6:0]  cursor_col_o,
  output logic [4:0]  cursor_row_o,
  output logic        busy_o
);

  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
  localparam logic [10:0] LINE_END  = 11'(COLS - 1);
  localparam logic [10:0] LAST_CELL = 11'(CELLS - 1);

  state_t      state_q;
  logic [6:0]  col_q;
  logic [4:0]  row_q;
  logic [7:0]  byte_q;
  logic        adv_q;
  logic [10:0] cnt_q;

  logic [4:0]  row_next_d;
  logic        printable_d;

  // row*80 without a multiplier: row*64 + row*16
  function automatic logic [10:0] row_base(input logic [4:0] r);
    logic [10:0] rw;
    rw = {6'd0, r};
    return (rw << 6) + (rw << 4);
  endfunction

  assign row_next_d  = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
  assign printable_d = (char_data_i >= 8'h20) && (char_data_i <= 8'h7E);

  assign char_ready_o = !rst && (state_q == IDLE);
  assign busy_o       = rst || (state_q != IDLE);
  assign cursor_col_o = col_q;
  assign cursor_row_o = row_q;

  always_comb begin
    ram_wren_o = 1'b0;
    ram_addr_o = 11'd0;
    ram_data_o = SPACE;
    case (state_q)
      PUT: begin
        ram_wren_o = 1'b1;
        ram_addr_o = row_base(row_q) + {4'd0, col_q};
        ram_data_o = byte_q;
      end
      CLR_LINE: begin
        ram_wren_o = 1'b1;
        ram_addr_o = row_base(row_q) + cnt_q;
      end
      CLR_SCR: begin
        ram_wren_o = 1'b1;
        ram_addr_o = cnt_q;
      end
      default: ;
    endcase
    // Reset suppresses the strobe immediately, not one cycle later
    if (rst) ram_wren_o = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLR_SCR;
      cnt_q   <= 11'd0;
      col_q   <= 7'd0;
      row_q   <= 5'd0;
      adv_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (char_valid_i) begin
            byte_q <= (char_data_i == BS) ? SPACE : char_data_i;
            if (printable_d) begin
              adv_q   <= 1'b1;
              state_q <= PUT;
            end else if (char_data_i == LF) begin
              col_q   <= 7'd0;
              row_q   <= row_next_d;
              cnt_q   <= 11'd0;
              state_q <= CLR_LINE;
            end else if (char_data_i == CR) begin
              col_q <= 7'd0;
            end else if (char_data_i == BS) begin
              // Cursor moves first so the blanking write lands on the new cell
              if (col_q != 7'd0) begin
                col_q   <= col_q - 7'd1;
                adv_q   <= 1'b0;
                state_q <= PUT;
              end else if (row_q != 5'd0) begin
                col_q   <= LAST_COL;
                row_q   <= row_q - 5'd1;
                adv_q   <= 1'b0;
                state_q <= PUT;
              end
            end else if (char_data_i == FF) begin
              cnt_q   <= 11'd0;
              state_q <= CLR_SCR;
            end
          end
        end
        PUT: begin
          if (adv_q && (col_q == LAST_COL)) begin
            col_q   <= 7'd0;
            row_q   <= row_next_d;
            cnt_q   <= 11'd0;
            state_q <= CLR_LINE;
          end else begin
            if (adv_q) col_q <= col_q + 7'd1;
            state_q <= IDLE;
          end
        end
        CLR_LINE: begin
          if (cnt_q == LINE_END) state_q <= IDLE;
          else                   cnt_q   <= cnt_q + 11'd1;
        end
        CLR_SCR: begin
          if (cnt_q == LAST_CELL) begin
            col_q   <= 7'd0;
            row_q   <= 5'd0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 11'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_term_writer.sv
// Directed scoreboard bench for term_writer: expected RAM writes are queued
// as bytes are sent and popped by a write monitor.
module tb_term_writer;
  import term_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  char_data = 8'h00;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic [10:0] ram_addr;
  logic [7:0]  ram_data;
  logic        ram_wren;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  term_writer dut (
    .clk          (clk),
    .rst          (rst),
    .char_data_i  (char_data),
    .char_valid_i (char_valid),
    .char_ready_o (char_ready),
    .ram_addr_o   (ram_addr),
    .ram_data_o   (ram_data),
    .ram_wren_o   (ram_wren),
    .cursor_col_o (cursor_col),
    .cursor_row_o (cursor_row),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  writes = 0;
  int  w0;

  always @(negedge clk) begin
    if (ram_wren === 1'b1) begin
      writes++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL unexpected_write got addr=%0d data=%h, expected no write", ram_addr, ram_data);
      end else begin
        mon_e = exp_q.pop_front();
        assert ({ram_addr, ram_data} === mon_e) else begin
          errors++;
          $error("FAIL ram_write got addr=%0d data=%h expected addr=%0d data=%h",
                 ram_addr, ram_data, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input int addr, input logic [7:0] data);
    wr_t e;
    e.addr = 11'(addr);
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic push_clear(input int base, input int n);
    for (int i = 0; i < n; i++) push_wr(base + i, SPACE);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (char_ready !== 1'b1 && n < 5000) begin
      step();
      n++;
    end
    if (n >= 5000) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Returns in the cycle after acceptance
  task automatic send(input logic [7:0] b);
    wait_ready("send");
    char_data  = b;
    char_valid = 1'b1;
    step();
    char_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    wait_ready(tag);
    check({tag, "_sb_empty"}, exp_q.size(), 32'd0);
  endtask

  task automatic check_cur(input string tag, input int row, input int col);
    check({tag, "_row"}, {27'd0, cursor_row}, row);
    check({tag, "_col"}, {25'd0, cursor_col}, col);
  endtask

  initial begin
    // Power-up clear
    push_clear(0, CELLS);
    repeat (3) step();
    check("rst_wren", {31'd0, ram_wren}, 32'd0);
    check("rst_ready", {31'd0, char_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check_cur("rst_cursor", 0, 0);
    writes = 0;
    rst = 1'b0;
    wait_idle("init");
    check("init_writes", writes, 32'd2000);
    check_cur("init_cursor", 0, 0);
    check("init_busy", {31'd0, busy}, 32'd0);

    // Single printable: write next cycle, ready two cycles after acceptance
    push_wr(0, 8'h41);
    send(8'h41);
    check("A_wren", {31'd0, ram_wren}, 32'd1);
    check("A_ready_n1", {31'd0, char_ready}, 32'd0);
    step();
    check("A_ready_n2", {31'd0, char_ready}, 32'd1);
    check_cur("A_cursor", 0, 1);
    check("A_sb_empty", exp_q.size(), 32'd0);

    // Fill to column 79
    for (int c = 1; c < 79; c++) begin
      push_wr(c, 8'h61 + 8'(c % 26));
      send(8'h61 + 8'(c % 26));
    end
    wait_idle("fill");
    check_cur("fill_cursor", 0, 79);

    // Last column wraps and clears the next row
    push_wr(79, 8'h42);
    push_clear(80, 80);
    send(8'h42);
    check("wrap_wren", {31'd0, ram_wren}, 32'd1);
    step();
    check_cur("wrap_cursor_mid", 1, 0);
    check("wrap_ready_mid", {31'd0, char_ready}, 32'd0);
    wait_idle("wrap");
    check_cur("wrap_cursor", 1, 0);

    // Backspace across a row boundary
    push_wr(79, SPACE);
    send(BS);
    check_cur("bs_cursor", 0, 79);
    check("bs_wren", {31'd0, ram_wren}, 32'd1);
    wait_idle("bs");

    // Carriage return
    send(CR);
    check("cr_wren", {31'd0, ram_wren}, 32'd0);
    check("cr_ready", {31'd0, char_ready}, 32'd1);
    check_cur("cr_cursor", 0, 0);

    // Line feeds down to the last row
    for (int r = 1; r < ROWS; r++) begin
      push_clear(r * COLS, COLS);
      send(LF);
      wait_idle("lf_walk");
    end
    check_cur("lf_walk_cursor", 24, 0);
    for (int i = 0; i < 5; i++) begin
      push_wr(1920 + i, 8'h30 + 8'(i));
      send(8'h30 + 8'(i));
    end
    wait_idle("row24");
    check_cur("row24_cursor", 24, 5);

    // LF on the last row wraps to row 0 with no character write
    push_clear(0, COLS);
    send(LF);
    wait_idle("lf_wrap");
    check_cur("lf_wrap_cursor", 0, 0);

    // Backspace at home does nothing
    w0 = writes;
    send(BS);
    check("bs_home_wren", {31'd0, ram_wren}, 32'd0);
    step();
    check("bs_home_writes", writes, w0);
    check_cur("bs_home_cursor", 0, 0);
    check("bs_home_ready", {31'd0, char_ready}, 32'd1);

    // Form feed clears the screen and homes the cursor at the end
    push_wr(0, 8'h5A);
    send(8'h5A);
    wait_idle("pre_ff");
    check_cur("pre_ff_cursor", 0, 1);
    push_clear(0, CELLS);
    send(FF);
    repeat (100) step();
    check_cur("ff_cursor_mid", 0, 1);
    check("ff_busy_mid", {31'd0, busy}, 32'd1);
    wait_idle("ff");
    check_cur("ff_cursor", 0, 0);

    // Reset in the middle of a line clear
    push_clear(80, 80);
    send(LF);
    repeat (10) step();
    rst = 1'b1;
    exp_q.delete();
    push_clear(0, CELLS);
    #1;
    check("mid_rst_wren", {31'd0, ram_wren}, 32'd0);
    check("mid_rst_ready", {31'd0, char_ready}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd1);
    step();
    check_cur("mid_rst_cursor", 0, 0);
    rst = 1'b0;
    writes = 0;
    wait_idle("mid_rst");
    check("mid_rst_writes", writes, 32'd2000);
    check_cur("mid_rst_cursor_end", 0, 0);

    // Unprintable bytes are consumed with no effect
    w0 = writes;
    send(8'h07);
    check("bel_wren", {31'd0, ram_wren}, 32'd0);
    check("bel_ready", {31'd0, char_ready}, 32'd1);
    send(8'hFF);
    check("ff_byte_wren", {31'd0, ram_wren}, 32'd0);
    check("ff_byte_ready", {31'd0, char_ready}, 32'd1);
    step();
    check("junk_writes", writes, w0);
    check_cur("junk_cursor", 0, 0);
    check("final_sb_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
